// File: rtl/freq_sweep_ctrl_if.sv
// Bus bundle between the sweep controller and its environment: sweep
// control/configuration, the step-value calculator loop and status pulses.
interface freq_sweep_ctrl_if #(
  parameter int FREQ_W  = 20,
  parameter int DWELL_W = 24
);
  logic               start;
  logic               abort;
  logic               mode;
  logic [FREQ_W-1:0]  f_start;
  logic [FREQ_W-1:0]  f_stop;
  logic [FREQ_W-1:0]  f_inc;
  logic [DWELL_W-1:0] dwell;
  logic [FREQ_W-1:0]  freq;
  logic [31:0]        step_in;
  logic [31:0]        step_out;
  logic               step_load;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, abort, mode, f_start, f_stop, f_inc, dwell, step_in,
    input  freq, step_out, step_load, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_inc, dwell, step_in,
    output freq, step_out, step_load, busy, done, cfg_err
  );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps freq from f_start to f_stop, waits for the
// external calculator latency, loads the phase step and dwells on each step.

module freq_sweep_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic step_load,
  input logic busy,
  input logic done,
  input logic cfg_err
);
  a_load_busy: assert property (@(posedge clk) disable iff (!rst_n) step_load |-> busy);
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_cfg_idle:  assert property (@(posedge clk) disable iff (!rst_n) cfg_err |-> !busy);
  a_pulses:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0({step_load, done, cfg_err}));
endmodule

module freq_sweep_ctrl #(
  parameter int FREQ_W   = 20,
  parameter int DWELL_W  = 24,
  parameter int CALC_LAT = 8
) (
  input logic              clk,
  input logic              rst_n,
  freq_sweep_ctrl_if.slave sif
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam logic [FREQ_W-1:0]  F_ZERO   = {FREQ_W{1'b0}};
  localparam logic [DWELL_W-1:0] D_ZERO   = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] D_ONE    = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]         LAT_INIT = 8'(CALC_LAT);

  state_t             state_r;
  logic [FREQ_W-1:0]  f_start_r;
  logic [FREQ_W-1:0]  f_stop_r;
  logic [FREQ_W-1:0]  f_inc_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               mode_r;
  logic [FREQ_W-1:0]  freq_r;
  logic [31:0]        step_r;
  logic               step_load_r;
  logic               done_r;
  logic               cfg_err_r;
  logic               busy_r;
  logic [7:0]         lat_cnt_r;
  logic [DWELL_W-1:0] dwell_cnt_r;

  logic [FREQ_W:0]    next_freq_s;
  logic               past_stop_s;
  logic               cfg_bad_s;
  logic [DWELL_W-1:0] dwell_load_s;

  // Next-step arithmetic with one carry bit; a carry always lands past f_stop.
  always_comb begin
    next_freq_s = {1'b0, freq_r} + {1'b0, f_inc_r};
    past_stop_s = (next_freq_s > {1'b0, f_stop_r});
    cfg_bad_s   = (sif.f_inc == F_ZERO) || (sif.f_start > sif.f_stop);
    if (dwell_r == D_ZERO) begin
      dwell_load_s = D_ONE;
    end else begin
      dwell_load_s = dwell_r;
    end
  end

  // Sweep sequencer with all outputs registered; abort outranks every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      f_start_r   <= F_ZERO;
      f_stop_r    <= F_ZERO;
      f_inc_r     <= F_ZERO;
      dwell_r     <= D_ZERO;
      mode_r      <= 1'b0;
      freq_r      <= F_ZERO;
      step_r      <= 32'd0;
      step_load_r <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      lat_cnt_r   <= 8'd0;
      dwell_cnt_r <= D_ZERO;
    end else begin
      step_load_r <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sif.start && !sif.abort) begin
            if (cfg_bad_s) begin
              cfg_err_r <= 1'b1;
            end else begin
              f_start_r <= sif.f_start;
              f_stop_r  <= sif.f_stop;
              f_inc_r   <= sif.f_inc;
              dwell_r   <= sif.dwell;
              mode_r    <= sif.mode;
              freq_r    <= sif.f_start;
              lat_cnt_r <= LAT_INIT;
              busy_r    <= 1'b1;
              state_r   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (sif.abort) begin
            lat_cnt_r <= 8'd0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (lat_cnt_r == 8'd1) begin
            lat_cnt_r   <= 8'd0;
            step_r      <= sif.step_in;
            step_load_r <= 1'b1;
            dwell_cnt_r <= dwell_load_s;
            state_r     <= ST_DWELL;
          end else begin
            lat_cnt_r <= lat_cnt_r - 8'd1;
          end
        end
        ST_DWELL: begin
          if (sif.abort) begin
            dwell_cnt_r <= D_ZERO;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (dwell_cnt_r == D_ONE) begin
            dwell_cnt_r <= D_ZERO;
            if (!past_stop_s) begin
              freq_r    <= next_freq_s[FREQ_W-1:0];
              lat_cnt_r <= LAT_INIT;
              state_r   <= ST_CALC;
            end else if (mode_r) begin
              freq_r    <= f_start_r;
              lat_cnt_r <= LAT_INIT;
              state_r   <= ST_CALC;
            end else begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r - D_ONE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sif.freq      = freq_r;
  assign sif.step_out  = step_r;
  assign sif.step_load = step_load_r;
  assign sif.busy      = busy_r;
  assign sif.done      = done_r;
  assign sif.cfg_err   = cfg_err_r;

  freq_sweep_ctrl_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_load (step_load_r),
    .busy      (busy_r),
    .done      (done_r),
    .cfg_err   (cfg_err_r)
  );
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: a timeline model derived from the
// sweep arithmetic is compared with the DUT every cycle, plus literal pins.
module tb_freq_sweep_ctrl;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  freq_sweep_ctrl_if #(.FREQ_W(20), .DWELL_W(24)) sif ();

  freq_sweep_ctrl #(.FREQ_W(20), .DWELL_W(24), .CALC_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s_cyc = 0;
  logic chk_en = 1'b0;
  logic force_si = 1'b0;

  // model state: idle hold values plus the parameters of the running sweep
  logic        m_act = 1'b0;
  logic [19:0] m_freq = 20'd0;
  logic [31:0] m_step = 32'd0;
  longint      m_t0, m_fs, m_inc, m_n, m_p;
  logic        m_mode;
  logic [19:0] e_freq = 20'd0;
  logic [31:0] e_step = 32'd0;
  logic        e_load = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_cfg = 1'b0;

  int n_loads = 0, n_dones = 0, n_cfg = 0, done_cyc = 0, cfg_cyc = 0;
  int load_cyc [64];

  function automatic logic [31:0] hsh(input logic [19:0] f);
    return {12'hA5C, f} ^ 32'h0F0F_3C3C;
  endfunction

  // Outputs c edges after the start edge: step k occupies P cycles, load at offset LAT.
  function automatic void exp_at(input longint c, output logic [19:0] f,
                                 output logic [31:0] s, output logic ld);
    longint k, r, kk, kp;
    k  = c / m_p;
    r  = c % m_p;
    kk = m_mode ? (k % m_n) : k;
    f  = 20'(m_fs + kk * m_inc);
    ld = (r == LAT);
    if (r >= LAT) s = hsh(f);
    else if (k == 0) s = m_step;
    else begin
      kp = m_mode ? ((k - 1) % m_n) : (k - 1);
      s  = hsh(20'(m_fs + kp * m_inc));
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model, advanced once per rising edge.
  always @(posedge clk or negedge rst_n) begin
    logic [19:0] f;
    logic [31:0] s;
    logic        ld;
    longint      c;
    if (!rst_n) begin
      m_act = 1'b0; m_freq = 20'd0; m_step = 32'd0;
      e_freq = 20'd0; e_step = 32'd0; e_load = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cfg = 1'b0;
    end else begin
      cyc++;
      e_done = 1'b0;
      e_cfg  = 1'b0;
      if (m_act) begin
        c = longint'(cyc) - m_t0;
        if (sif.abort) begin
          exp_at(c - 1, f, s, ld);
          m_freq = f; m_step = s; m_act = 1'b0;
        end else if (!m_mode && c >= m_n * m_p) begin
          m_freq = 20'(m_fs + (m_n - 1) * m_inc);
          m_step = hsh(m_freq);
          m_act  = 1'b0;
          e_done = 1'b1;
        end
      end else if (sif.start && !sif.abort) begin
        if (sif.f_inc == 20'd0 || sif.f_start > sif.f_stop) e_cfg = 1'b1;
        else begin
          m_act  = 1'b1;
          m_t0   = cyc;
          m_fs   = sif.f_start;
          m_inc  = sif.f_inc;
          m_mode = sif.mode;
          m_n    = (longint'(sif.f_stop) - m_fs) / m_inc + 1;
          m_p    = LAT + ((sif.dwell == 24'd0) ? 1 : longint'(sif.dwell));
        end
      end
      if (m_act) begin
        exp_at(longint'(cyc) - m_t0, e_freq, e_step, e_load);
        e_busy = 1'b1;
      end else begin
        e_freq = m_freq; e_step = m_step; e_load = 1'b0; e_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("freq", sif.freq, e_freq);
      chk("step_out", sif.step_out, e_step);
      chk("step_load", sif.step_load, e_load);
      chk("busy", sif.busy, e_busy);
      chk("done", sif.done, e_done);
      chk("cfg_err", sif.cfg_err, e_cfg);
    end
  end

  // Event bookkeeping for the literal checks.
  always @(negedge clk) begin
    if (sif.step_load) begin
      if (n_loads < 64) load_cyc[n_loads] = cyc;
      n_loads++;
    end
    if (sif.done) begin n_dones++; done_cyc = cyc; end
    if (sif.cfg_err) begin n_cfg++; cfg_cyc = cyc; end
  end

  // Calculator stand-in: step_in reflects freq only after LAT stable cycles.
  initial begin
    logic [31:0] pipe [LAT];
    for (int i = 0; i < LAT; i++) pipe[i] = 32'd0;
    sif.step_in = 32'd0;
    forever begin
      @(posedge clk); #1;
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = hsh(sif.freq);
      sif.step_in = force_si ? 32'hDEAD_BEEF : pipe[LAT-1];
    end
  end

  task automatic setcfg(input logic [19:0] fs, input logic [19:0] fp, input logic [19:0] inc,
                        input logic [23:0] dw, input logic md);
    sif.f_start = fs; sif.f_stop = fp; sif.f_inc = inc; sif.dwell = dw; sif.mode = md;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    sif.start = 1'b1;
    s_cyc = cyc + 1;
    @(posedge clk); #2;
    sif.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_dones;
    int i = 0;
    while (n_dones == d0 && i < budget) begin @(negedge clk); #1; i++; end
    chk("done_seen", 64'(n_dones != d0), 64'd1);
  endtask

  task automatic wait_loads(input int target, input int budget);
    int i = 0;
    while (n_loads < target && i < budget) begin @(negedge clk); #1; i++; end
    chk("loads_seen", 64'(n_loads >= target), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, d, g;
    rst_n = 1'b1;
    sif.start = 1'b0; sif.abort = 1'b0;
    setcfg(20'd0, 20'd0, 20'd0, 24'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_freq", sif.freq, 20'd0);
    chk("rst_busy", sif.busy, 1'b0);
    idle(3);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(3);

    // single sweep; inputs scrambled after start must not matter
    setcfg(20'd1000, 20'd1300, 20'd100, 24'd4, 1'b0);
    b = n_loads; d = n_dones;
    pulse_start();
    setcfg(20'd3, 20'd5, 20'd1, 24'd0, 1'b1);
    wait_done(200);
    idle(4);
    chk("s1_loads", n_loads - b, 4);
    chk("s1_dones", n_dones - d, 1);
    chk("s1_first", load_cyc[b] - s_cyc, 8);
    chk("s1_space", load_cyc[b+1] - load_cyc[b], 12);
    chk("s1_done_at", done_cyc - s_cyc, 48);
    chk("s1_freq", sif.freq, 20'd1300);
    chk("s1_step", sif.step_out, hsh(20'd1300));

    // configuration errors and start+abort
    g = n_cfg;
    setcfg(20'd100, 20'd200, 20'd0, 24'd4, 1'b0);
    pulse_start(); idle(2);
    chk("cfg_inc0", n_cfg - g, 1);
    chk("cfg_at", cfg_cyc - s_cyc, 0);
    chk("cfg_busy", sif.busy, 1'b0);
    setcfg(20'd500, 20'd400, 20'd10, 24'd4, 1'b0);
    pulse_start(); idle(2);
    chk("cfg_order", n_cfg - g, 2);
    setcfg(20'd1000, 20'd1300, 20'd100, 24'd4, 1'b0);
    sif.abort = 1'b1;
    pulse_start(); idle(1);
    sif.abort = 1'b0;
    idle(2);
    chk("abort_start_cfg", n_cfg - g, 2);
    chk("abort_start_busy", sif.busy, 1'b0);
    chk("abort_start_freq", sif.freq, 20'd1300);

    // continuous wrap, abort after 6th load
    setcfg(20'd1000, 20'd1300, 20'd100, 24'd4, 1'b1);
    b = n_loads; d = n_dones;
    pulse_start();
    wait_loads(b + 6, 200);
    @(posedge clk); #2 sif.abort = 1'b1;
    @(posedge clk); #2 sif.abort = 1'b0;
    idle(4);
    chk("wrap_dones", n_dones - d, 0);
    chk("wrap_loads", n_loads - b, 6);
    chk("wrap_freq", sif.freq, 20'd1100);
    chk("wrap_busy", sif.busy, 1'b0);

    // carry out of the top of the range ends the sweep
    setcfg(20'hFFF00, 20'hFFFFF, 20'h00100, 24'd2, 1'b0);
    b = n_loads;
    pulse_start();
    wait_done(100);
    idle(3);
    chk("ovf_loads", n_loads - b, 1);
    chk("ovf_freq", sif.freq, 20'hFFF00);

    // dwell of zero, with an ignored start mid-sweep
    setcfg(20'd10, 20'd30, 20'd10, 24'd0, 1'b0);
    b = n_loads; g = n_cfg;
    pulse_start();
    idle(5);
    setcfg(20'd50, 20'd40, 20'd0, 24'd9, 1'b1);
    pulse_start();
    wait_done(100);
    idle(3);
    chk("dw0_loads", n_loads - b, 3);
    chk("dw0_space", load_cyc[b+1] - load_cyc[b], 9);
    chk("dw0_cfg", n_cfg - g, 0);
    chk("dw0_freq", sif.freq, 20'd30);

    // single-step sweep
    setcfg(20'd777, 20'd777, 20'd5, 24'd3, 1'b0);
    b = n_loads; d = n_dones;
    pulse_start();
    wait_done(100);
    idle(3);
    chk("one_loads", n_loads - b, 1);
    chk("one_dones", n_dones - d, 1);
    chk("one_freq", sif.freq, 20'd777);

    // asynchronous reset mid-CALC with a pending step value
    setcfg(20'd1000, 20'd1300, 20'd100, 24'd4, 1'b0);
    b = n_loads;
    pulse_start();
    idle(3);
    force_si = 1'b1;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mr_freq", sif.freq, 20'd0);
    chk("mr_step", sif.step_out, 32'd0);
    chk("mr_load", sif.step_load, 1'b0);
    chk("mr_busy", sif.busy, 1'b0);
    idle(2);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(12);
    force_si = 1'b0;
    chk("mr_no_load", n_loads - b, 0);
    chk("mr_step_after", sif.step_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
